// File: rtl/godai_mem_trace_capture.sv
// Data-memory access trace recorder with show-ahead record FIFO.
// Optional branch records enabled by defining GODAI_TRACE_BRANCH_EN.
module godai_mem_trace_capture #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LAT_WIDTH  = 16,
  localparam int REC_WIDTH = 2 + 1 + 4 + ADDR_WIDTH + 32 + LAT_WIDTH,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           instr_count_i,
  input  logic                  pc_set_i,
  input  logic                  branch_decision_i,
  output logic                  trace_valid_o,
  input  logic                  trace_ready_i,
  output logic [REC_WIDTH-1:0]  trace_data_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic [15:0]           drop_count_o,
  output logic                  proto_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t                  state;
  logic                    cap_we;
  logic [3:0]              cap_be;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [31:0]             cap_ic;
  logic [LAT_WIDTH-1:0]    lat;

  logic                    gnt_ev;
  logic                    acc_start;
  logic                    mem_push;
  logic [REC_WIDTH-1:0]    mem_rec;
  logic                    br_hit;
  logic [REC_WIDTH-1:0]    br_rec;

  assign gnt_ev    = data_req_i & data_gnt_i;
  assign acc_start = gnt_ev & enable_i;
  assign mem_push  = (state == PEND) & data_rvalid_i;
  assign mem_rec   = {1'b0, cap_we, cap_we, cap_be,
                      cap_addr, cap_ic, lat};

`ifdef GODAI_TRACE_BRANCH_EN
  assign br_hit = pc_set_i & branch_decision_i & enable_i;
  assign br_rec = {2'b10, 1'b0, 4'b0,
                   {ADDR_WIDTH{1'b0}}, instr_count_i,
                   {LAT_WIDTH{1'b0}}};
`else
  logic unused_branch;
  assign unused_branch = pc_set_i ^ branch_decision_i;
  assign br_hit = 1'b0;
  assign br_rec = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_we      <= 1'b0;
      cap_be      <= '0;
      cap_addr    <= '0;
      cap_ic      <= '0;
      lat         <= '0;
      proto_err_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_rvalid_i)
            proto_err_o <= 1'b1;
          if (acc_start) begin
            cap_we   <= data_we_i;
            cap_be   <= data_be_i;
            cap_addr <= data_addr_i;
            cap_ic   <= instr_count_i;
            lat      <= LAT_WIDTH'(1);
            state    <= PEND;
          end
        end
        PEND: begin
          if (data_rvalid_i) begin
            // completion and next grant may coincide
            if (acc_start) begin
              cap_we   <= data_we_i;
              cap_be   <= data_be_i;
              cap_addr <= data_addr_i;
              cap_ic   <= instr_count_i;
              lat      <= LAT_WIDTH'(1);
            end else begin
              state <= IDLE;
            end
          end else begin
            if (gnt_ev)
              proto_err_o <= 1'b1;
            if (lat != '1)
              lat <= lat + LAT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [REC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;

  logic                 push;
  logic [REC_WIDTH-1:0] push_rec;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 fifo_drop;
  logic                 br_lost;
  logic [1:0]           drop_inc;
  logic [16:0]          drop_sum;

  assign push      = mem_push | br_hit;
  assign push_rec  = mem_push ? mem_rec : br_rec;
  assign br_lost   = mem_push & br_hit;
  assign pop       = trace_valid_o & trace_ready_i;
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign wr_en     = push & (~full | pop);
  assign fifo_drop = push & full & ~pop;
  assign drop_inc  = {1'b0, fifo_drop} + {1'b0, br_lost};
  assign drop_sum  = {1'b0, drop_count_o} + {15'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      drop_count_o <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case (1'b1)
        (wr_en & ~pop): level <= level + LVL_W'(1);
        (pop & ~wr_en): level <= level - LVL_W'(1);
        default:        level <= level;
      endcase
      // saturate rather than wrap
      if (drop_sum[16])
        drop_count_o <= '1;
      else
        drop_count_o <= drop_sum[15:0];
    end
  end

  assign trace_valid_o = (level != '0);
  assign trace_data_o  = mem[rd_ptr];
  assign fifo_level_o  = level;

endmodule

// File: tb/tb_godai_mem_trace_capture.sv
// Self-checking bench for godai_mem_trace_capture.
// Scoreboard queue of expected records, vector table plus corner sequences.
module tb_godai_mem_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        data_req_i;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] instr_count_i;
  logic        pc_set_i;
  logic        branch_decision_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [86:0] trace_data_o;
  logic [3:0]  fifo_level_o;
  logic [15:0] drop_count_o;
  logic        proto_err_o;

  int checks = 0;
  int failures = 0;
  logic [86:0] sb [$];

  godai_mem_trace_capture dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable_i          (enable_i),
    .data_req_i        (data_req_i),
    .data_gnt_i        (data_gnt_i),
    .data_rvalid_i     (data_rvalid_i),
    .data_we_i         (data_we_i),
    .data_be_i         (data_be_i),
    .data_addr_i       (data_addr_i),
    .instr_count_i     (instr_count_i),
    .pc_set_i          (pc_set_i),
    .branch_decision_i (branch_decision_i),
    .trace_valid_o     (trace_valid_o),
    .trace_ready_i     (trace_ready_i),
    .trace_data_o      (trace_data_o),
    .fifo_level_o      (fifo_level_o),
    .drop_count_o      (drop_count_o),
    .proto_err_o       (proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] ic;
    int          n;
    logic [86:0] exp;
  } vec_t;

  function automatic logic [86:0] mk_rec(
    logic [1:0] t, logic we, logic [3:0] be,
    logic [31:0] a, logic [31:0] ic, logic [15:0] lat);
    return {t, we, be, a, ic, lat};
  endfunction

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic we, input logic [3:0] be,
                        input logic [31:0] a,
                        input logic [31:0] ic, input int n,
                        input bit keep, input logic [86:0] exp);
    if (keep) sb.push_back(exp);
    data_req_i    = 1'b1;
    data_gnt_i    = 1'b1;
    data_we_i     = we;
    data_be_i     = be;
    data_addr_i   = a;
    instr_count_i = ic;
    step();
    data_req_i = 1'b0;
    data_gnt_i = 1'b0;
    repeat (n - 1) step();
    data_rvalid_i = 1'b1;
    step();
    data_rvalid_i = 1'b0;
  endtask

  task automatic drain(string nm);
    trace_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !trace_valid_o) break;
      step();
    end
    chk({nm, "_left"}, sb.size(), 0);
    chk({nm, "_level"}, fifo_level_o, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && trace_valid_o && trace_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record actual=%0h required=none",
                 trace_data_o);
      end else begin
        chk("record", trace_data_o, sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  vec_t vt [5];

  initial begin
    vt[0] = '{1'b0, 4'hF, 32'h100, 32'h10, 3, '0};
    vt[1] = '{1'b1, 4'h3, 32'h2000_0004, 32'h55, 1, '0};
    vt[2] = '{1'b0, 4'h1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 7, '0};
    vt[3] = '{1'b1, 4'hC, 32'h0, 32'h0, 2, '0};
    vt[4] = '{1'b1, 4'hA, 32'hDEAD_BEE0, 32'h1234, 20, '0};
    foreach (vt[i])
      vt[i].exp = mk_rec({1'b0, vt[i].we}, vt[i].we, vt[i].be,
                         vt[i].addr, vt[i].ic, 16'(vt[i].n));

    rst_n = 1'b0;
    enable_i = 1'b1;
    data_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
    data_we_i = 0; data_be_i = 0; data_addr_i = 0;
    instr_count_i = 0; pc_set_i = 0; branch_decision_i = 0;
    trace_ready_i = 1'b1;
    repeat (3) step();
    chk("rst_valid", trace_valid_o, 0);
    chk("rst_data", trace_data_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_drop", drop_count_o, 0);
    chk("rst_perr", proto_err_o, 0);
    rst_n = 1'b1;
    repeat (2) step();

    foreach (vt[i]) begin
      access(vt[i].we, vt[i].be, vt[i].addr, vt[i].ic,
             vt[i].n, 1'b1, vt[i].exp);
      step();
    end
    drain("table");

    // back-to-back: store, then load granted on its rvalid
    sb.push_back(mk_rec(2'b01, 1, 4'h5, 32'h40, 32'h7, 16'd1));
    data_req_i = 1; data_gnt_i = 1; data_we_i = 1;
    data_be_i = 4'h5; data_addr_i = 32'h40; instr_count_i = 32'h7;
    step();
    sb.push_back(mk_rec(2'b00, 0, 4'h5, 32'h44, 32'h8, 16'd1));
    data_rvalid_i = 1; data_we_i = 0;
    data_addr_i = 32'h44; instr_count_i = 32'h8;
    step();
    data_req_i = 0; data_gnt_i = 0;
    step();
    data_rvalid_i = 0;
    drain("b2b");

    // enable dropped while pending still records
    sb.push_back(mk_rec(2'b00, 0, 4'h2, 32'h80, 32'h9, 16'd2));
    data_req_i = 1; data_gnt_i = 1; data_we_i = 0;
    data_be_i = 4'h2; data_addr_i = 32'h80; instr_count_i = 32'h9;
    step();
    data_req_i = 0; data_gnt_i = 0; enable_i = 0;
    step();
    data_rvalid_i = 1;
    step();
    data_rvalid_i = 0; enable_i = 1;
    drain("en_pend");
    chk("perr_clean", proto_err_o, 0);

    // overflow
    trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++)
      access(i[0], 4'hF, 32'h1000 + 32'(i * 4), 32'(i), 1, i < 8,
             mk_rec({1'b0, i[0]}, i[0], 4'hF,
                    32'h1000 + 32'(i * 4), 32'(i), 16'd1));
    step();
    chk("ovf_level", fifo_level_o, 8);
    chk("ovf_drop", drop_count_o, 2);
    drain("ovf");

    // full FIFO: pop and push in the same cycle
    trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++)
      access(1'b0, 4'h1, 32'h3000 + 32'(i), 32'(i), 1, 1'b1,
             mk_rec(2'b00, 0, 4'h1, 32'h3000 + 32'(i),
                    32'(i), 16'd1));
    step();
    chk("full_level", fifo_level_o, 8);
    sb.push_back(mk_rec(2'b01, 1, 4'h8, 32'h3F00, 32'h99, 16'd1));
    data_req_i = 1; data_gnt_i = 1; data_we_i = 1;
    data_be_i = 4'h8; data_addr_i = 32'h3F00; instr_count_i = 32'h99;
    step();
    data_req_i = 0; data_gnt_i = 0;
    data_rvalid_i = 1; trace_ready_i = 1;
    step();
    data_rvalid_i = 0; trace_ready_i = 0;
    step();
    chk("pp_level", fifo_level_o, 8);
    chk("pp_drop", drop_count_o, 2);
    drain("pp");

    // rvalid with nothing pending
    data_rvalid_i = 1;
    step();
    data_rvalid_i = 0;
    step();
    chk("perr_set", proto_err_o, 1);
    chk("perr_level", fifo_level_o, 0);
    repeat (3) step();
    chk("perr_sticky", proto_err_o, 1);

    // enable low: no capture
    enable_i = 0;
    access(1'b1, 4'hF, 32'h5000, 32'h1, 2, 1'b0, '0);
    step();
    chk("en_low_level", fifo_level_o, 0);
    enable_i = 1;

`ifdef GODAI_TRACE_BRANCH_EN
    trace_ready_i = 0;
    sb.push_back(mk_rec(2'b10, 0, 4'h0, 32'h0, 32'h20, 16'd0));
    pc_set_i = 1; branch_decision_i = 1; instr_count_i = 32'h20;
    step();
    pc_set_i = 0; branch_decision_i = 0;
    step();
    chk("br_level", fifo_level_o, 1);
    drain("br");
`endif

    // reset during a pending access
    trace_ready_i = 0;
    data_req_i = 1; data_gnt_i = 1; data_we_i = 0;
    data_addr_i = 32'h6000; instr_count_i = 32'h3;
    step();
    data_req_i = 0; data_gnt_i = 0;
    step();
    rst_n = 0;
    #2;
    chk("mid_rst_valid", trace_valid_o, 0);
    chk("mid_rst_level", fifo_level_o, 0);
    chk("mid_rst_drop", drop_count_o, 0);
    chk("mid_rst_perr", proto_err_o, 0);
    chk("mid_rst_data", trace_data_o, 0);
    step();
    rst_n = 1;
    trace_ready_i = 1;
    repeat (5) step();
    chk("post_rst_valid", trace_valid_o, 0);
    chk("post_rst_level", fifo_level_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
